// File: rtl/multicycle_ctrl_hs_if.sv
// Handshake/control bundle between the instruction register, memory port and datapath
// and the multicycle controller.
interface multicycle_ctrl_hs_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       overflow;
  logic       memAck;
  logic       memReq;
  logic       instWrite;
  logic [3:0] instType;
  logic       regWrite;
  logic       aluSrcA;
  logic       memRead;
  logic       memWrite;
  logic       memToReg;
  logic       isFetch;
  logic       isJump;
  logic       isBranch;
  logic       reversedZFlag;
  logic [1:0] aluSrcB;
  logic       trap;
  logic [1:0] trapCause;
  logic       retire;
  logic [2:0] stateOut;

  // Controller side: it is the requester on the memory port.
  modport master (
    input  opcode, funct3, overflow, memAck,
    output memReq, instWrite, instType, regWrite, aluSrcA, memRead, memWrite,
           memToReg, isFetch, isJump, isBranch, reversedZFlag, aluSrcB,
           trap, trapCause, retire, stateOut
  );

  modport slave (
    output opcode, funct3, overflow, memAck,
    input  memReq, instWrite, instType, regWrite, aluSrcA, memRead, memWrite,
           memToReg, isFetch, isJump, isBranch, reversedZFlag, aluSrcB,
           trap, trapCause, retire, stateOut
  );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// RV32I multicycle control FSM with memory req/ack handshake, wait-state timeout,
// illegal-opcode detection and optional ALU-overflow trap.
//
// state      | meaning
// IDLE       | after reset; all outputs low
// FETCH      | instruction read request, wait for memAck
// DECODE     | latch opcode/funct3, reject unknown opcodes
// EXECUTE    | ALU operation; branches retire here
// MEM_ACCESS | data load/store request, wait for memAck
// WRITEBACK  | register write and retire
// TRAP       | sticky until reset; trapCause holds the reason
module multicycle_ctrl_hs #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_ON_OVF = 1'b0,
  parameter int CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input logic                  CLK,
  input logic                  RES_N,
  multicycle_ctrl_hs_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_EXECUTE = 3'b011;
  localparam logic [2:0] S_MEM     = 3'b100;
  localparam logic [2:0] S_WB      = 3'b101;
  localparam logic [2:0] S_TRAP    = 3'b111;

  localparam logic [3:0] T_NONE  = 4'd0;
  localparam logic [3:0] T_R     = 4'd1;
  localparam logic [3:0] T_I     = 4'd2;
  localparam logic [3:0] T_JALR  = 4'd3;
  localparam logic [3:0] T_LOAD  = 4'd4;
  localparam logic [3:0] T_STORE = 4'd5;
  localparam logic [3:0] T_B     = 4'd6;
  localparam logic [3:0] T_JAL   = 4'd7;
  localparam logic [3:0] T_LUI   = 4'd8;
  localparam logic [3:0] T_AUIPC = 4'd9;

  localparam logic [1:0] C_TIMEOUT = 2'b01;
  localparam logic [1:0] C_ILLEGAL = 2'b10;
  localparam logic [1:0] C_OVF     = 2'b11;

  localparam bit               TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(MEM_TIMEOUT);

  function automatic logic [3:0] itype_of(input logic [6:0] op);
    case (op)
      7'b0110011: itype_of = T_R;
      7'b0010011: itype_of = T_I;
      7'b1100111: itype_of = T_JALR;
      7'b0000011: itype_of = T_LOAD;
      7'b0100011: itype_of = T_STORE;
      7'b1100011: itype_of = T_B;
      7'b1101111: itype_of = T_JAL;
      7'b0110111: itype_of = T_LUI;
      7'b0010111: itype_of = T_AUIPC;
      default:    itype_of = T_NONE;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [6:0]       op_q, op_d;
  logic             f3_lsb_q, f3_lsb_d;
  logic [1:0]       cause_q, cause_d;

  logic [3:0]       ity;
  logic             tmo_hit;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             ovf_trap;

  assign ity          = itype_of(op_q);
  assign tmo_hit      = TMO_EN && (wait_cnt_q == TMO);
  assign wait_cnt_inc = (wait_cnt_q == TMO) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
  assign ovf_trap     = TRAP_ON_OVF && bus.overflow && ((ity == T_R) || (ity == T_I));

  // wait_cnt_d defaults to zero, so every state change clears the counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    op_d       = op_q;
    f3_lsb_d   = f3_lsb_q;
    cause_d    = cause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.memAck) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = C_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      S_DECODE: begin
        op_d     = bus.opcode;
        f3_lsb_d = bus.funct3[0];
        if (itype_of(bus.opcode) == T_NONE) begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (ovf_trap) begin
          state_d = S_TRAP;
          cause_d = C_OVF;
        end else if (ity == T_B) begin
          state_d = S_FETCH;
        end else if ((ity == T_LOAD) || (ity == T_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.memAck) begin
          state_d = (ity == T_STORE) ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = C_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      op_q       <= '0;
      f3_lsb_q   <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
      f3_lsb_q   <= f3_lsb_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    bus.memReq        = 1'b0;
    bus.instWrite     = 1'b0;
    bus.instType      = T_NONE;
    bus.regWrite      = 1'b0;
    bus.aluSrcA       = 1'b0;
    bus.memRead       = 1'b0;
    bus.memWrite      = 1'b0;
    bus.memToReg      = 1'b0;
    bus.isFetch       = 1'b0;
    bus.isJump        = 1'b0;
    bus.isBranch      = 1'b0;
    bus.reversedZFlag = 1'b0;
    bus.aluSrcB       = 2'b00;
    bus.trap          = 1'b0;
    bus.trapCause     = 2'b00;
    bus.retire        = 1'b0;
    bus.stateOut      = state_q;
    case (state_q)
      S_FETCH: begin
        bus.memReq    = 1'b1;
        bus.memRead   = 1'b1;
        bus.isFetch   = 1'b1;
        bus.instWrite = bus.memAck;
      end
      S_EXECUTE: begin
        bus.instType = ity;
        case (ity)
          T_I, T_LOAD, T_STORE, T_LUI: bus.aluSrcB = 2'b10;
          T_AUIPC: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = 2'b10;
          end
          T_JALR: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = 2'b11;
            bus.isJump  = 1'b1;
          end
          T_JAL: bus.isJump = 1'b1;
          T_B: begin
            bus.isBranch      = 1'b1;
            bus.reversedZFlag = f3_lsb_q;
            bus.retire        = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.memReq   = 1'b1;
        bus.memRead  = (ity == T_LOAD);
        bus.memWrite = (ity == T_STORE);
        bus.aluSrcB  = 2'b10;
        bus.retire   = bus.memAck && (ity == T_STORE);
      end
      S_WB: begin
        bus.regWrite = 1'b1;
        bus.retire   = 1'b1;
        bus.memToReg = (ity == T_LOAD);
        bus.isJump   = (ity == T_JAL) || (ity == T_JALR);
      end
      S_TRAP: begin
        bus.trap      = 1'b1;
        bus.trapCause = cause_q;
      end
      default: ;
    endcase
  end

endmodule
